// File: rtl/ls190_seq.sv
// Sequencer for a two-decade sn74ls190 BCD counter: loads a BCD preset, counts
// it to 00 (down) or 99 (up), stops exactly at the terminal value and pulses done.
module ls190_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] preset,
    input  logic       dir,
    input  logic       reload,
    input  logic [7:0] cnt_q,
    output logic [7:0] cnt_d,
    output logic       cnt_load_n,
    output logic       cnt_en_n,
    output logic       cnt_updn,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] cnt_d_q, cnt_d_d;
    logic       cnt_load_n_q, cnt_load_n_d;
    logic       cnt_updn_q, cnt_updn_d;
    logic       reload_q, reload_d;
    logic       done_q, done_d;
    logic       err_q, err_d;

    logic [7:0] term;
    logic       at_term;
    logic       q_valid;

    function automatic logic is_bcd(input logic [7:0] v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

    assign term    = cnt_updn_q ? 8'h99 : 8'h00;
    assign at_term = (cnt_q == term);
    assign q_valid = is_bcd(cnt_q);

    // abort outranks start, terminal detection and readback errors
    always_comb begin
        state_d      = state_q;
        cnt_d_d      = cnt_d_q;
        cnt_updn_d   = cnt_updn_q;
        reload_d     = reload_q;
        cnt_load_n_d = 1'b1;
        done_d       = 1'b0;
        err_d        = 1'b0;

        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (!is_bcd(preset)) begin
                            err_d = 1'b1;
                        end else begin
                            cnt_d_d      = preset;
                            cnt_updn_d   = dir;
                            reload_d     = reload;
                            cnt_load_n_d = 1'b0;
                            state_d      = LOAD;
                        end
                    end
                end
                LOAD: begin
                    state_d = RUN;
                end
                RUN: begin
                    if (at_term) begin
                        done_d = 1'b1;
                        if (reload_q) begin
                            cnt_load_n_d = 1'b0;
                            state_d      = LOAD;
                        end else begin
                            state_d = IDLE;
                        end
                    end else if (!q_valid) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_d_q      <= 8'h00;
            cnt_load_n_q <= 1'b1;
            cnt_updn_q   <= 1'b0;
            reload_q     <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_d_q      <= cnt_d_d;
            cnt_load_n_q <= cnt_load_n_d;
            cnt_updn_q   <= cnt_updn_d;
            reload_q     <= reload_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    // Enable is combinational so the counter can never step past the terminal value
    assign cnt_en_n   = !((state_q == RUN) && !abort && !at_term && q_valid);
    assign busy       = (state_q != IDLE);
    assign cnt_d      = cnt_d_q;
    assign cnt_load_n = cnt_load_n_q;
    assign cnt_updn   = cnt_updn_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule
